// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: A and B are added one bit per clock, LSB first.
// The n+1 bit sum appears on S together with a one-cycle done pulse.
module serial_adder #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n:0]   S,
    output logic         busy,
    output logic         done
);

    localparam int cw = $clog2(n) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [n-1:0]   opa;
    logic [n-1:0]   opb;
    logic [n-1:0]   result;
    logic           carry;
    logic [cw-1:0]  count;

    logic           sumbit;
    logic           carrynext;
    logic [n-1:0]   resultnext;
    logic           lastbit;

    // One full-adder slice; new sum bits enter the result from the MSB side.
    always_comb begin
        sumbit     = opa[0] ^ opb[0] ^ carry;
        carrynext  = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
        resultnext = n'({sumbit, result} >> 1);
        lastbit    = (count == cw'(n - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (lastbit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // S changes only on the final ADD edge, so it stays stable while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            carry  <= 1'b0;
            count  <= '0;
            S      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        carry <= 1'b0;
                        count <= '0;
                    end
                end
                ADD: begin
                    opa    <= opa >> 1;
                    opb    <= opb >> 1;
                    result <= resultnext;
                    carry  <= carrynext;
                    count  <= count + cw'(1);
                    if (lastbit) begin
                        S <= {carrynext, resultnext};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (n=4): vector table, exhaustive and
// randomized operands against an arithmetic reference, throughput and reset cases.
module tb_serial_adder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N:0]   S;
    logic         busy;
    logic         done;

    int           checkCount = 0;
    int           passCount  = 0;
    logic [N:0]   prevS;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N:0]   s;
    } vec_t;

    vec_t table_v[6];

    serial_adder #(.n(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .S    (S),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] refSum(input logic [N-1:0] a, input logic [N-1:0] b);
        int total;
        total = int'(a) + int'(b);
        return total[N:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        else
            passCount++;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N:0] expS, input bit scramble);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        if (!scramble) start = 1'b0;
        for (int k = 0; k < N; k++) begin
            checkOutput("busy_in_add", busy, 1);
            checkOutput("done_early", done, 0);
            checkOutput("s_hold_in_add", S, prevS);
            if (scramble) begin
                A = N'($urandom);
                B = N'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("sum", S, expS);
        @(negedge clk);
        checkOutput("done_width", done, 0);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("sum_held", S, expS);
        start = 1'b0;
        prevS = expS;
    endtask

    initial begin
        int pulses;
        int last;
        int doneSeen;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        table_v[0] = '{a: 4'hF, b: 4'hF, s: 5'h1E};
        table_v[1] = '{a: 4'h9, b: 4'h6, s: 5'h0F};
        table_v[2] = '{a: 4'h0, b: 4'h0, s: 5'h00};
        table_v[3] = '{a: 4'h8, b: 4'h8, s: 5'h10};
        table_v[4] = '{a: 4'h7, b: 4'h1, s: 5'h08};
        table_v[5] = '{a: 4'hA, b: 4'h5, s: 5'h0F};

        rst = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_s", S, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prevS = '0;

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++)
            applyStimulus(table_v[i].a, table_v[i].b, table_v[i].s, 1'b0);

        $display("[TB] exhaustive back-to-back");
        for (int i = 0; i < 256; i++)
            applyStimulus(N'(i >> 4), N'(i), refSum(N'(i >> 4), N'(i)), 1'b0);

        $display("[TB] randomized with inputs toggling during ADD");
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            applyStimulus(ra, rb, refSum(ra, rb), 1'b1);
        end

        $display("[TB] start held high");
        A = 4'h3;
        B = 4'h4;
        start = 1'b1;
        pulses = 0;
        last = -1;
        for (int c = 0; c < 40 && pulses < 3; c++) begin
            @(negedge clk);
            if (done) begin
                if (pulses > 0) checkOutput("done_spacing", c - last, 6);
                checkOutput("held_sum", S, refSum(4'h3, 4'h4));
                last = c;
                pulses++;
            end
        end
        checkOutput("held_pulse_count", pulses, 3);
        start = 1'b0;
        @(negedge clk);
        prevS = refSum(4'h3, 4'h4);

        $display("[TB] reset during ADD");
        A = 4'h5;
        B = 4'h6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_done", done, 0);
        checkOutput("async_rst_s", S, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("no_done_after_reset", doneSeen, 0);
        checkOutput("idle_after_reset", busy, 0);
        prevS = '0;
        applyStimulus(4'hC, 4'h7, refSum(4'hC, 4'h7), 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter n, default 4, operand width in bits; legal range n >= 1.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 A  input  n  unsigned addend; captured on the accepting edge.
REQ-006 B  input  n  unsigned addend; captured on the accepting edge.
REQ-007 S  output  n+1  registered sum A+B; MSB is the carry-out.
REQ-008 busy  output  1  high while bits are being processed (ADD state).
REQ-009 done  output  1  one-cycle pulse; S valid and newly updated.

Function
REQ-010 FSM states SHALL be IDLE, ADD and DONE; busy = (state==ADD), done = (state==DONE), both decoded from registered state.
REQ-011 IDLE: on a rising edge with start=1, the block SHALL load A and B into operand shift registers, clear carry, clear the bit counter, and enter ADD.
REQ-012 ADD: each edge SHALL add the operand LSBs plus carry, shift the sum bit into the result register from the MSB side, shift both operands right by one, update carry, and increment the counter.
REQ-013 ADD SHALL exit to DONE on the edge that processes bit n-1 (counter==n-1), loading S = {carry_out, result} on that same edge.
REQ-014 DONE SHALL last exactly one cycle, then return unconditionally to IDLE.
REQ-015 Latency: accepting start at edge 0 SHALL give busy=1 after edges 0..n-1, done=1 after edge n, and state IDLE after edge n+1.
REQ-016 Throughput: start held high SHALL start a new operation every n+2 cycles.
REQ-017 start SHALL be ignored in ADD and DONE, with no queuing.
REQ-018 A and B changes after capture SHALL NOT affect the result in flight.
REQ-019 S SHALL hold its previous value until the next DONE entry, so it is stable during ADD.
REQ-020 The result SHALL be exact unsigned A+B in n+1 bits, with no overflow possible; for n=1 the block SHALL behave as a full adder with carry-in 0.
REQ-021 The counter SHALL be sized ceil(log2(n))+1 bits or wider, with no wrap before n-1.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force state=IDLE and busy=0, done=0, S=0, and clear operand, result, carry and counter registers.
REQ-023 rst asserted mid-operation SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-024 After rst deasserts, the first clk edge with start=1 SHALL be accepted normally.

Verification (n=4)
REQ-025 A=4'hF, B=4'hF, start pulsed one cycle -> busy high 4 cycles, done pulse after edge 4, S=5'h1E held afterwards.
REQ-026 A=4'h9, B=4'h6 -> S=5'h0F (carry 0); then A=0, B=0 -> done still pulses, S=5'h00.
REQ-027 start and random A/B toggled every cycle during ADD -> start ignored, S equals the sum of the operands captured at acceptance; start held high -> done pulses spaced exactly 6 cycles.
REQ-028 rst pulsed 2 cycles into ADD, asynchronous to clk -> busy/done/S go 0 before the next edge; no done pulse within 10 cycles after release; next start completes correctly.
REQ-029 Exhaustive 256 A/B pairs, back-to-back -> every S equals A+B, and every done pulse is exactly one cycle wide.
